// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_pkg                                                       |
// | Shared types and constants for the rv32e instruction fetch stage.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state;

   localparam int unsigned INSTRUCTION_BYTES = 4;
   localparam int unsigned WORD_BITS         = 8 * INSTRUCTION_BYTES;

endpackage
`default_nettype wire

// File: rtl/skid_buffer_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | skid_buffer_port                                                     |
// | Valid/ready handshake bundle; downstream is the producing side.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface skid_buffer_port #(
   parameter int unsigned WIDTH = 32
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport downstream (output valid, output data, input ready);
   modport upstream   (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue                                                          |
// | Synchronous FIFO with push, pop and flush (flush beats push).        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 2,
   parameter int unsigned WIDTH       = WORD_BITS
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [$clog2(QUEUE_DEPTH):0] count,
   output logic                         empty,
   output logic [WIDTH-1:0]             head
);

   localparam int unsigned c_idx_w = $clog2(QUEUE_DEPTH);
   localparam int unsigned c_ptr_w = c_idx_w + 1;

   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [WIDTH-1:0]   r_mem [QUEUE_DEPTH];
   logic               w_do_push;
   logic               w_do_pop;

   assign w_do_push = push && !flush;
   assign w_do_pop  = pop && !empty;

   // The extra pointer bit tells full from empty when the indices match.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[c_idx_w-1:0]] <= push_data;
      end
   end

   assign count = r_wr_ptr - r_rd_ptr;
   assign empty = (count == '0);
   assign head  = r_mem[r_rd_ptr[c_idx_w-1:0]];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit                                                           |
// | rv32e fetch stage: PC, imem read issue, queue toward decode.         |
// | Option macro: FETCH_ALIGN_CHECK_EN (misaligned redirect -> FAULT).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned QUEUE_DEPTH  = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   skid_buffer_port.downstream        to_decode,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [31:0]                imem_addr,
   input  logic                       imem_resp_valid,
   input  logic [31:0]                imem_resp_data,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_target,
   output logic                       fetch_fault
);

   localparam int unsigned         c_cnt_w = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [c_cnt_w:0]    c_depth = (c_cnt_w + 1)'(QUEUE_DEPTH);

   fetch_state         r_state;
   logic [31:0]        r_pc;
   logic [c_cnt_w-1:0] r_outstanding;
   logic [c_cnt_w-1:0] r_drop;

   logic [c_cnt_w-1:0] w_outstanding_next;
   logic [c_cnt_w-1:0] w_count;
   logic               w_empty;
   logic [31:0]        w_head;
   logic               w_req_fire;
   logic               w_push;
   logic               w_pop;
   logic               w_flush;
   logic               w_redirect;
   logic               w_misaligned;
   logic [31:0]        w_target;

`ifdef FETCH_ALIGN_CHECK_EN
   assign w_misaligned = (redirect_target[1:0] != 2'b00);
   assign fetch_fault  = (r_state == FAULT);
`else
   assign w_misaligned = 1'b0;
   assign fetch_fault  = 1'b0;
`endif

   assign w_target   = redirect_target & ~32'h0000_0003;
   assign w_redirect = (r_state == RUN) && redirect_valid;

   // Issue only while every in-flight word is guaranteed a queue slot.
   assign imem_req_valid = (r_state == RUN) &&
                           (({1'b0, r_outstanding} + {1'b0, w_count}) < c_depth);
   assign imem_addr      = r_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   assign w_outstanding_next = r_outstanding + c_cnt_w'(w_req_fire)
                                             - c_cnt_w'(imem_resp_valid);

   assign w_push  = imem_resp_valid && (r_drop == '0);
   assign w_pop   = to_decode.valid && to_decode.ready;
   assign w_flush = w_redirect || (r_state == FAULT);

   fetch_queue #(
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .WIDTH       (WORD_BITS)
   ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push),
      .push_data (imem_resp_data),
      .pop       (w_pop),
      .flush     (w_flush),
      .count     (w_count),
      .empty     (w_empty),
      .head      (w_head)
   );

   assign to_decode.valid = !w_empty;
   assign to_decode.data  = w_head;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= BOOT;
         r_pc          <= RESET_VECTOR;
         r_outstanding <= '0;
         r_drop        <= '0;
      end else begin
         r_outstanding <= w_outstanding_next;
         if (imem_resp_valid && (r_drop != '0)) begin
            r_drop <= r_drop - c_cnt_w'(1);
         end
         if (w_req_fire) begin
            r_pc <= r_pc + 32'(INSTRUCTION_BYTES);
         end
         case (r_state)
            BOOT: begin
               r_state <= RUN;
            end
            RUN: begin
               // Every word still owed by memory after this edge is stale.
               if (w_redirect) begin
                  r_drop <= w_outstanding_next;
                  r_pc   <= w_target;
                  if (w_misaligned) begin
                     r_state <= FAULT;
                  end
               end
            end
            FAULT: begin
               r_state <= FAULT;
            end
            default: begin
               r_state <= BOOT;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
